pio_bank: RTL and testbench
===========================

PIO_BANK -- requirements
Module: pio_bank

Interface
REQ-001 Parameter WIDTH, default 32, bits per channel (1..32).
REQ-002 Parameter N_CH, default 2, number of channels (1..8).
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-006 avs_address  in  3+clog2(N_CH)  word address {channel, reg offset[2:0]}.
REQ-007 avs_read, avs_write  in  1 each  Avalon-MM strobes.
REQ-008 avs_writedata  in  32  write data; bits >= WIDTH ignored.
REQ-009 avs_readdata  out  32  read data, zero-extended above WIDTH.
REQ-010 avs_readdatavalid  out  1  read-data qualifier; no waitrequest, slave never stalls.
REQ-011 irq  out  1  level interrupt, registered.
REQ-012 pio_in_export  in  N_CH*WIDTH  asynchronous pins, channel c at [c*WIDTH +: WIDTH].
REQ-013 pio_out_export, pio_oe_export  out  N_CH*WIDTH each  output latch, output enable (1 = drive).

Function
REQ-014 Per-channel register offsets: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR, 6 RISE_EN, 7 FALL_EN.
REQ-015 DATA write loads output latch; DATA read returns, per bit, output latch if DIR=1 else synchronised input.
REQ-016 OUTSET write ORs data into latch; OUTCLR write clears latch bits where data=1; reads of 4/5 return 0.
REQ-017 DIR drives pio_oe_export directly; latch drives pio_out_export directly; both change the cycle after the write.
REQ-018 Inputs pass through SYNC_STAGES flops, then one delay flop; rising edge = sync&~prev, falling = ~sync&prev.
REQ-019 EDGECAP bit sets on a detected edge whose RISE_EN/FALL_EN bit is 1, regardless of DIR or IRQMASK.
REQ-020 Pin transition to EDGECAP set latency: exactly SYNC_STAGES+1 cycles.
REQ-021 EDGECAP write is write-1-to-clear; simultaneous set and clear on the same bit: set wins.
REQ-022 irq = registered OR over channels of (EDGECAP & IRQMASK); asserts one cycle after the contributing EDGECAP bit is set.
REQ-023 Read: avs_readdata and avs_readdatavalid valid exactly one cycle after avs_read; readdatavalid is a 1-cycle pulse; readdata is 0 when not valid.
REQ-024 Back-to-back reads every cycle supported, one result per cycle, in order.
REQ-025 avs_read and avs_write together: write performed, read ignored, no readdatavalid.
REQ-026 Channel index >= N_CH: write ignored, read returns 0 with readdatavalid.
REQ-027 Write to EDGECAP read in the next cycle returns post-clear value.

Reset
REQ-028 While reset_reset_n=0 at a clock edge: all registers, latches, sync and delay flops, irq, avs_readdatavalid, avs_readdata cleared to 0.
REQ-029 Edge detection suppressed for SYNC_STAGES+1 cycles after reset release (settle counter) so a pin high at reset produces no EDGECAP.
REQ-030 Reset asserted mid-read: readdatavalid for that read not produced.

Structure
REQ-031 Package pio_bank_pkg holds register offset constants and the edge-mode enum; no module-specific parameters.
REQ-032 One sub-module pio_bank_chan (per-channel registers, synchroniser, edge capture), generated N_CH times; top holds decode, read mux, irq, settle counter.

Verification
REQ-033 Reset release with pio_in ch0 = 0xFFFFFFFF, RISE_EN=all -> EDGECAP ch0 reads 0, irq stays 0.
REQ-034 DIR ch1=0x0000FFFF, DATA ch1 write 0x12345678, pin 0xABCD0000 -> pio_out ch1 0x12345678, DATA read 0xABCD5678.
REQ-035 RISE_EN ch0 bit3, IRQMASK bit3, pin bit3 0->1 at cycle T -> EDGECAP bit3 at T+3, irq at T+4; W1C 0x8 -> irq low next cycle+1.
REQ-036 Pin rise arriving the same cycle as W1C of that bit -> EDGECAP bit remains 1.
REQ-037 OUTSET 0xF0 then OUTCLR 0x30 on latch 0x0F -> DATA readback (DIR all 1) 0xCF.
REQ-038 Reads on 4 consecutive cycles to ch0 DATA, ch0 DIR, channel N_CH (invalid), ch1 IRQMASK -> 4 consecutive readdatavalid pulses, third data 0.

Source files
------------

// File: rtl/pio_bank_pkg.sv
// Shared register map and edge-mode encoding for the PIO bank.
// Imported by the per-channel block and the bus-facing top.
package pio_bank_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IRQMASK = 3'd2;
  localparam logic [2:0] REG_EDGECAP = 3'd3;
  localparam logic [2:0] REG_OUTSET  = 3'd4;
  localparam logic [2:0] REG_OUTCLR  = 3'd5;
  localparam logic [2:0] REG_RISE_EN = 3'd6;
  localparam logic [2:0] REG_FALL_EN = 3'd7;

  // Per-bit capture mode formed as {FALL_EN, RISE_EN}.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

endpackage

// File: rtl/pio_bank_chan.sv
// One PIO channel: output latch, direction, irq mask, edge enables,
// input synchroniser and sticky edge-capture register.
module pio_bank_chan
  import pio_bank_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_off,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_off,
  input  logic             edge_en,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out_latch,
  output logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq_src
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] cap_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] cap_set_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic [WIDTH-1:0] pin_view_s;

  assign rise_s     = edge_en ? (sync_r[SYNC_STAGES-1] & ~prev_r) : ZERO;
  assign fall_s     = edge_en ? (~sync_r[SYNC_STAGES-1] & prev_r) : ZERO;
  assign cap_clr_s  = (wr_en && (wr_off == REG_EDGECAP)) ? wr_data : ZERO;
  assign pin_view_s = (out_latch & dir) | (sync_r[SYNC_STAGES-1] & ~dir);
  assign irq_src    = |(cap_r & mask_r);

  // Input synchroniser chain followed by the edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= ZERO;
      prev_r <= ZERO;
    end else begin
      sync_r[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Select which detected edges are captured, bit by bit.
  always_comb begin
    cap_set_s = ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      case (edge_mode_e'({fall_en_r[i], rise_en_r[i]}))
        EDGE_NONE: cap_set_s[i] = 1'b0;
        EDGE_RISE: cap_set_s[i] = rise_s[i];
        EDGE_FALL: cap_set_s[i] = fall_s[i];
        EDGE_BOTH: cap_set_s[i] = rise_s[i] | fall_s[i];
        default:   cap_set_s[i] = 1'b0;
      endcase
    end
  end

  // Register writes; the capture register lets a new edge override its clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_latch <= ZERO;
      dir       <= ZERO;
      mask_r    <= ZERO;
      rise_en_r <= ZERO;
      fall_en_r <= ZERO;
      cap_r     <= ZERO;
    end else begin
      if (wr_en) begin
        case (wr_off)
          REG_DATA:    out_latch <= wr_data;
          REG_DIR:     dir       <= wr_data;
          REG_IRQMASK: mask_r    <= wr_data;
          REG_OUTSET:  out_latch <= out_latch | wr_data;
          REG_OUTCLR:  out_latch <= out_latch & ~wr_data;
          REG_RISE_EN: rise_en_r <= wr_data;
          REG_FALL_EN: fall_en_r <= wr_data;
          default:     out_latch <= out_latch;
        endcase
      end else begin
        out_latch <= out_latch;
      end
      cap_r <= (cap_r & ~cap_clr_s) | cap_set_s;
    end
  end

  // Register read view for the bus mux in the top level.
  always_comb begin
    rd_data = ZERO;
    case (rd_off)
      REG_DATA:    rd_data = pin_view_s;
      REG_DIR:     rd_data = dir;
      REG_IRQMASK: rd_data = mask_r;
      REG_EDGECAP: rd_data = cap_r;
      REG_RISE_EN: rd_data = rise_en_r;
      REG_FALL_EN: rd_data = fall_en_r;
      default:     rd_data = ZERO;
    endcase
  end

endmodule

// File: rtl/pio_bank.sv
// Avalon-MM PIO bank: address decode, registered read path, irq
// aggregation and post-reset edge-detect settle counter.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [2+$clog2(N_CH):0] avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    irq,
  input  logic [N_CH*WIDTH-1:0]   pio_in_export,
  output logic [N_CH*WIDTH-1:0]   pio_out_export,
  output logic [N_CH*WIDTH-1:0]   pio_oe_export
);

  localparam int         CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

  logic [CH_W-1:0]  ch_sel_s;
  logic             ch_ok_s;
  logic             wr_s;
  logic             rd_s;
  logic             edge_en_s;
  logic [2:0]       settle_r;
  logic [WIDTH-1:0] chan_rd_s [N_CH];
  logic [N_CH-1:0]  irq_src_s;
  logic [WIDTH-1:0] rd_mux_s;

  if (N_CH > 1) begin : g_multi
    assign ch_sel_s = avs_address[2+$clog2(N_CH):3];
  end else begin : g_single
    assign ch_sel_s = 1'b0;
  end

  assign ch_ok_s   = (int'(ch_sel_s) < N_CH);
  assign wr_s      = avs_write && ch_ok_s;
  assign rd_s      = avs_read && !avs_write;
  assign edge_en_s = (settle_r == SETTLE);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pio_bank_chan #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .wr_en     (wr_s && (ch_sel_s == CH_W'(c))),
      .wr_off    (avs_address[2:0]),
      .wr_data   (avs_writedata[WIDTH-1:0]),
      .rd_off    (avs_address[2:0]),
      .edge_en   (edge_en_s),
      .pin       (pio_in_export[c*WIDTH +: WIDTH]),
      .out_latch (pio_out_export[c*WIDTH +: WIDTH]),
      .dir       (pio_oe_export[c*WIDTH +: WIDTH]),
      .rd_data   (chan_rd_s[c]),
      .irq_src   (irq_src_s[c])
    );
  end

  // Channel read-data select; unmapped channels read as zero.
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      if (ch_ok_s && (ch_sel_s == CH_W'(c))) rd_mux_s = chan_rd_s[c];
      else rd_mux_s = rd_mux_s;
    end
  end

  // Read response, irq register and settle counter.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= 32'h0;
      irq               <= 1'b0;
      settle_r          <= 3'd0;
    end else begin
      avs_readdatavalid <= rd_s;
      avs_readdata      <= rd_s ? 32'(rd_mux_s) : 32'h0;
      irq               <= |irq_src_s;
      settle_r          <= edge_en_s ? settle_r : (settle_r + 3'd1);
    end
  end

endmodule

// File: tb/tb_pio_bank.sv
// Scenario bench for pio_bank with a read-data scoreboard queue.
module tb_pio_bank;
  import pio_bank_pkg::*;

  logic        clk;
  logic        reset_reset_n;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [95:0] pio_in;
  logic [95:0] pio_out;
  logic [95:0] pio_oe;

  int          checks;
  int          failures;
  logic [31:0] q[$];
  logic [31:0] exp_d;

  pio_bank #(.WIDTH(32), .N_CH(3), .SYNC_STAGES(2)) dut (
    .clk_clk           (clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq),
    .pio_in_export     (pio_in),
    .pio_out_export    (pio_out),
    .pio_oe_export     (pio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] adr(input int ch, input logic [2:0] off);
    logic [1:0] c2;
    c2 = ch[1:0];
    return {c2, off};
  endfunction

  task automatic set_pin(input int ch, input logic [31:0] v);
    pio_in[ch*32 +: 32] = v;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic read_cycle(input logic [4:0] a, input logic [31:0] e);
    avs_read = 1'b1; avs_address = a;
    q.push_back(e);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    set_pin(0, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    checks++;
    if (pio_out !== 96'h0 || pio_oe !== 96'h0) begin
      failures++; $display("FAIL reset_pio out=%h oe=%h want 0", pio_out, pio_oe);
    end
    checks++;
    if (irq !== 1'b0 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
      failures++; $display("FAIL reset_bus irq=%b valid=%b data=%h want 0", irq, avs_readdatavalid, avs_readdata);
    end
    reset_reset_n = 1'b1;
    do_write(adr(0, REG_RISE_EN), 32'hFFFF_FFFF);
    do_write(adr(0, REG_IRQMASK), 32'hFFFF_FFFF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
        failures++; $display("FAIL settle_irq cycle=%0d got=%b want=0", k, irq);
      end
    end
    read_cycle(adr(0, REG_EDGECAP), 32'h0);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL settle_edgecap got=%h valid=%b want=%h", avs_readdata, avs_readdatavalid, exp_d);
    end
  endtask

  task automatic test_data_dir();
    set_pin(1, 32'hABCD_0000);
    do_write(adr(1, REG_DIR), 32'h0000_FFFF);
    checks++;
    if (pio_oe[63:32] !== 32'h0000_FFFF) begin
      failures++; $display("FAIL dir_oe got=%h want=0000ffff", pio_oe[63:32]);
    end
    do_write(adr(1, REG_DATA), 32'h1234_5678);
    checks++;
    if (pio_out[63:32] !== 32'h1234_5678 || pio_out[31:0] !== 32'h0) begin
      failures++; $display("FAIL data_out got=%h want=%h", pio_out[63:0], 64'h1234_5678_0000_0000);
    end
    repeat (3) @(negedge clk);
    read_cycle(adr(1, REG_DATA), 32'hABCD_5678);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL data_mixed got=%h want=%h", avs_readdata, exp_d);
    end
  endtask

  task automatic test_edge_irq();
    logic exp_irq;
    do_write(adr(0, REG_RISE_EN), 32'h8);
    do_write(adr(0, REG_IRQMASK), 32'h8);
    set_pin(0, 32'h0);
    repeat (4) @(negedge clk);
    set_pin(0, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      avs_read = 1'b0;
      exp_irq = (k >= 4);
      checks++;
      if (irq !== exp_irq) begin
        failures++; $display("FAIL edge_irq k=%0d got=%b want=%b", k, irq, exp_irq);
      end
      if (k >= 2) begin
        checks++; exp_d = q.pop_front();
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
          failures++; $display("FAIL edge_latency k=%0d got=%h want=%h", k, avs_readdata, exp_d);
        end
      end
      if (k <= 3) begin
        avs_read = 1'b1; avs_address = adr(0, REG_EDGECAP);
        q.push_back((k == 3) ? 32'h8 : 32'h0);
      end
    end
    do_write(adr(0, REG_EDGECAP), 32'h8);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL w1c_irq_hold got=%b want=1", irq);
    end
    read_cycle(adr(0, REG_EDGECAP), 32'h0);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL w1c_read got=%h want=%h", avs_readdata, exp_d);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL w1c_irq_low got=%b want=0", irq);
    end
  endtask

  task automatic test_set_wins();
    set_pin(0, 32'h0);
    repeat (4) @(negedge clk);
    set_pin(0, 32'h8);
    repeat (5) @(negedge clk);
    set_pin(0, 32'h0);
    repeat (4) @(negedge clk);
    set_pin(0, 32'h8);
    repeat (2) @(negedge clk);
    do_write(adr(0, REG_EDGECAP), 32'h8);
    read_cycle(adr(0, REG_EDGECAP), 32'h8);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL set_wins got=%h want=%h", avs_readdata, exp_d);
    end
    do_write(adr(0, REG_EDGECAP), 32'h8);
    read_cycle(adr(0, REG_EDGECAP), 32'h0);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL plain_clear got=%h want=%h", avs_readdata, exp_d);
    end
  endtask

  task automatic test_outset_outclr();
    do_write(adr(2, REG_DIR), 32'hFFFF_FFFF);
    do_write(adr(2, REG_DATA), 32'h0F);
    do_write(adr(2, REG_OUTSET), 32'hF0);
    do_write(adr(2, REG_OUTCLR), 32'h30);
    checks++;
    if (pio_out[95:64] !== 32'hCF) begin
      failures++; $display("FAIL setclr_out got=%h want=000000cf", pio_out[95:64]);
    end
    read_cycle(adr(2, REG_DATA), 32'hCF);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL setclr_read got=%h want=%h", avs_readdata, exp_d);
    end
    read_cycle(adr(2, REG_OUTSET), 32'h0);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL outset_read got=%h want=%h", avs_readdata, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  b_addr [4];
    logic [31:0] b_exp  [4];
    do_write(adr(1, REG_IRQMASK), 32'h5A5A);
    do_write(adr(3, REG_DATA), 32'hFFFF_FFFF);
    do_write(adr(3, REG_DIR), 32'hFFFF_FFFF);
    checks++;
    if (pio_out !== {32'hCF, 32'h1234_5678, 32'h0} || pio_oe !== {32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0}) begin
      failures++; $display("FAIL bad_ch_write out=%h oe=%h want unchanged", pio_out, pio_oe);
    end
    b_addr[0] = adr(0, REG_DATA);    b_exp[0] = pio_in[31:0];
    b_addr[1] = adr(0, REG_DIR);     b_exp[1] = 32'h0;
    b_addr[2] = adr(3, REG_DATA);    b_exp[2] = 32'h0;
    b_addr[3] = adr(1, REG_IRQMASK); b_exp[3] = 32'h5A5A;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        avs_read = 1'b1; avs_address = b_addr[k]; q.push_back(b_exp[k]);
      end else begin
        avs_read = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (k < 4) begin
        exp_d = q.pop_front();
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
          failures++; $display("FAIL b2b k=%0d got=%h valid=%b want=%h", k, avs_readdata, avs_readdatavalid, exp_d);
        end
      end else if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
        failures++; $display("FAIL b2b_idle k=%0d got=%h valid=%b want 0", k, avs_readdata, avs_readdatavalid);
      end
    end
  endtask

  task automatic test_rw_collision();
    avs_read = 1'b1; avs_write = 1'b1;
    avs_address = adr(0, REG_IRQMASK); avs_writedata = 32'h1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    checks++;
    if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
      failures++; $display("FAIL rw_valid got=%b data=%h want 0", avs_readdatavalid, avs_readdata);
    end
    read_cycle(adr(0, REG_IRQMASK), 32'h1);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL rw_write got=%h want=%h", avs_readdata, exp_d);
    end
  endtask

  task automatic test_reset_mid_read();
    avs_read = 1'b1; avs_address = adr(1, REG_DIR);
    reset_reset_n = 1'b0;
    @(negedge clk);
    avs_read = 1'b0;
    checks++;
    if (avs_readdatavalid !== 1'b0) begin
      failures++; $display("FAIL reset_read_valid got=%b want=0", avs_readdatavalid);
    end
    @(negedge clk);
    reset_reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pio_out !== 96'h0 || pio_oe !== 96'h0 || irq !== 1'b0) begin
      failures++; $display("FAIL reset_clear out=%h oe=%h irq=%b want 0", pio_out, pio_oe, irq);
    end
    read_cycle(adr(1, REG_DIR), 32'h0);
    checks++; exp_d = q.pop_front();
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_d) begin
      failures++; $display("FAIL reset_dir got=%h want=%h", avs_readdata, exp_d);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_reset_n = 1'b0;
    avs_address = 5'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'h0;
    pio_in = 96'h0;
    test_reset();
    test_data_dir();
    test_edge_irq();
    test_set_wins();
    test_outset_outclr();
    test_back_to_back();
    test_rw_collision();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
